// File: rtl/raid_stripe_store.sv
// Rotating-parity stripe storage: NUM_DISKS x DEPTH words with full-stripe read/write,
// single-word corruption injection and a sequential per-disk wipe that models disk failure.
module raid_stripe_store #(
    parameter int NUM_DISKS = 3,
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 8,
    parameter int DIDX_W    = $clog2(NUM_DISKS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [ADDR_W-1:0]               cmd_addr,
    input  logic [(NUM_DISKS-1)*DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0]               cmd_parity,
    input  logic                            inj_valid,
    output logic                            inj_ready,
    input  logic [ADDR_W-1:0]               inj_addr,
    input  logic [DIDX_W-1:0]               inj_slot,
    input  logic [DATA_W-1:0]               inj_data,
    input  logic                            fail_valid,
    input  logic [DIDX_W-1:0]               fail_disk,
    output logic                            rd_valid,
    output logic [(NUM_DISKS-1)*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]               rd_parity,
    output logic [ADDR_W-1:0]               rd_addr,
    output logic                            rd_err,
    output logic                            wr_done,
    output logic [NUM_DISKS-1:0]            disk_ok,
    output logic                            busy,
    output logic                            wipe_done
);
    localparam int unsigned ND      = NUM_DISKS;
    localparam int unsigned SLOTS_U = NUM_DISKS - 1;
    localparam int unsigned DEPTH_U = DEPTH;
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {IDLE, WIPE} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] mem [NUM_DISKS][DEPTH];
    logic [IDX_W-1:0]  wipe_cnt;
    logic [DIDX_W-1:0] wipe_disk;

    logic [DIDX_W-1:0] cmd_p, inj_p, inj_disk;
    logic [IDX_W-1:0]  cmd_idx, inj_idx;
    logic              cmd_in_range, cmd_rd, cmd_wr;
    logic              inj_hit, fail_req, fail_acc;
    logic [(NUM_DISKS-1)*DATA_W-1:0] rd_data_nx;
    logic [DATA_W-1:0]               rd_parity_nx;

    function automatic logic [DIDX_W-1:0] parity_disk(input logic [ADDR_W-1:0] addr);
        int unsigned a;
        a = 32'(addr);
        return DIDX_W'(a % ND);
    endfunction

    // Data slots fill the physical disks in ascending order, stepping over the parity disk.
    function automatic logic [DIDX_W-1:0] slot_disk(input logic [DIDX_W-1:0] p, input int unsigned k);
        return (k < 32'(p)) ? DIDX_W'(k) : DIDX_W'(k + 1);
    endfunction

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_A;
    endfunction

    always_comb begin
        cmd_ready    = (state == IDLE);
        inj_ready    = (state == IDLE) && !cmd_valid;
        busy         = (state == WIPE);
        cmd_rd       = cmd_valid && cmd_ready && !cmd_write;
        cmd_wr       = cmd_valid && cmd_ready && cmd_write;
        cmd_p        = parity_disk(cmd_addr);
        cmd_idx      = cmd_addr[IDX_W-1:0];
        cmd_in_range = addr_ok(cmd_addr);
        inj_p        = parity_disk(inj_addr);
        inj_disk     = slot_disk(inj_p, 32'(inj_slot));
        inj_idx      = inj_addr[IDX_W-1:0];
        inj_hit      = inj_valid && inj_ready && (32'(inj_slot) < SLOTS_U)
                       && addr_ok(inj_addr) && disk_ok[inj_disk];
        fail_req     = fail_valid && (state == IDLE) && !cmd_valid && !inj_valid;
        fail_acc     = fail_req && (32'(fail_disk) < ND) && disk_ok[fail_disk];
    end

    always_comb begin
        rd_data_nx   = '0;
        rd_parity_nx = '0;
        if (cmd_in_range) begin
            for (int unsigned k = 0; k < SLOTS_U; k++) begin
                if (disk_ok[slot_disk(cmd_p, k)])
                    rd_data_nx[k*DATA_W +: DATA_W] = mem[slot_disk(cmd_p, k)][cmd_idx];
            end
            if (disk_ok[cmd_p])
                rd_parity_nx = mem[cmd_p][cmd_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fail_acc) state_nx = WIPE;
            WIPE:    if (wipe_cnt == LAST_IDX) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned d = 0; d < ND; d++)
                for (int unsigned w = 0; w < DEPTH_U; w++)
                    mem[d][w] <= '0;
            disk_ok   <= '1;
            wipe_cnt  <= '0;
            wipe_disk <= '0;
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
            rd_parity <= '0;
            wr_done   <= 1'b0;
            wipe_done <= 1'b0;
        end else begin
            rd_valid  <= cmd_rd;
            rd_err    <= cmd_rd && !cmd_in_range;
            rd_addr   <= cmd_rd ? cmd_addr : '0;
            rd_data   <= cmd_rd ? rd_data_nx : '0;
            rd_parity <= cmd_rd ? rd_parity_nx : '0;
            wr_done   <= cmd_wr || inj_hit;
            // A rejected fail still completes immediately so the requester is never left waiting.
            wipe_done <= (fail_req && !fail_acc) || (busy && wipe_cnt == LAST_IDX);
            if (cmd_wr && cmd_in_range) begin
                for (int unsigned k = 0; k < SLOTS_U; k++) begin
                    if (disk_ok[slot_disk(cmd_p, k)])
                        mem[slot_disk(cmd_p, k)][cmd_idx] <= cmd_data[k*DATA_W +: DATA_W];
                end
                if (disk_ok[cmd_p])
                    mem[cmd_p][cmd_idx] <= cmd_parity;
            end
            if (inj_hit)
                mem[inj_disk][inj_idx] <= inj_data;
            if (fail_acc) begin
                disk_ok[fail_disk] <= 1'b0;
                wipe_disk          <= fail_disk;
                wipe_cnt           <= '0;
            end
            if (busy) begin
                mem[wipe_disk][wipe_cnt] <= '0;
                wipe_cnt <= (wipe_cnt == LAST_IDX) ? '0 : wipe_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_raid_stripe_store.sv
// Scoreboard bench for raid_stripe_store: 3-disk/4-deep instance with a reference array model,
// plus a 5-disk/8-deep instance exercising the wider slot mapping.
module tb_raid_stripe_store;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [23:0] cmd_data;
    logic [11:0] cmd_parity;
    logic        inj_valid, inj_ready;
    logic [7:0]  inj_addr;
    logic [1:0]  inj_slot;
    logic [11:0] inj_data;
    logic        fail_valid;
    logic [1:0]  fail_disk;
    logic        rd_valid, rd_err, wr_done, busy, wipe_done;
    logic [23:0] rd_data;
    logic [11:0] rd_parity;
    logic [7:0]  rd_addr;
    logic [2:0]  disk_ok;

    logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
    logic [7:0]  b_cmd_addr;
    logic [47:0] b_cmd_data;
    logic [11:0] b_cmd_parity;
    logic        b_inj_valid, b_inj_ready;
    logic [7:0]  b_inj_addr;
    logic [2:0]  b_inj_slot;
    logic [11:0] b_inj_data;
    logic        b_fail_valid;
    logic [2:0]  b_fail_disk;
    logic        b_rd_valid, b_rd_err, b_wr_done, b_busy, b_wipe_done;
    logic [47:0] b_rd_data;
    logic [11:0] b_rd_parity;
    logic [7:0]  b_rd_addr;
    logic [4:0]  b_disk_ok;

    raid_stripe_store #(.NUM_DISKS(3), .DEPTH(4), .DATA_W(12), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_parity(cmd_parity),
        .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_addr(inj_addr),
        .inj_slot(inj_slot), .inj_data(inj_data),
        .fail_valid(fail_valid), .fail_disk(fail_disk),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_parity(rd_parity),
        .rd_addr(rd_addr), .rd_err(rd_err), .wr_done(wr_done),
        .disk_ok(disk_ok), .busy(busy), .wipe_done(wipe_done)
    );

    raid_stripe_store #(.NUM_DISKS(5), .DEPTH(8), .DATA_W(12), .ADDR_W(8)) dut_wide (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data), .cmd_parity(b_cmd_parity),
        .inj_valid(b_inj_valid), .inj_ready(b_inj_ready), .inj_addr(b_inj_addr),
        .inj_slot(b_inj_slot), .inj_data(b_inj_data),
        .fail_valid(b_fail_valid), .fail_disk(b_fail_disk),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_parity(b_rd_parity),
        .rd_addr(b_rd_addr), .rd_err(b_rd_err), .wr_done(b_wr_done),
        .disk_ok(b_disk_ok), .busy(b_busy), .wipe_done(b_wipe_done)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] data;
        logic [11:0] par;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          wd_cnt = 0;
    int          wd_exp = 0;
    logic [11:0] m [3][4];
    logic        okm [3];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Physical disk holding logical slot k: walk disks upward, skipping the parity disk.
    function automatic int phys_disk(input int a, input int k, input int nd);
        int p;
        int n;
        p = a % nd;
        n = 0;
        for (int d = 0; d < nd; d++) begin
            if (d != p) begin
                if (n == k) return d;
                n++;
            end
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            okm[d] = 1'b1;
            for (int w = 0; w < 4; w++) m[d][w] = '0;
        end
    endtask

    task automatic push_read(input int a);
        exp_t e;
        e.addr = 8'(a);
        e.err  = (a >= 4);
        e.data = '0;
        e.par  = '0;
        if (a < 4) begin
            for (int k = 0; k < 2; k++)
                if (okm[phys_disk(a, k, 3)]) e.data[k*12 +: 12] = m[phys_disk(a, k, 3)][a];
            if (okm[a % 3]) e.par = m[a % 3][a];
        end
        sb.push_back(e);
    endtask

    task automatic do_read(input int a);
        push_read(a);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'(a);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [23:0] d, input logic [11:0] p);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'(a); cmd_data = d; cmd_parity = p;
        tick();
        cmd_valid = 1'b0;
        check("wr_done", {63'd0, wr_done}, 64'd1);
        if (a < 4) begin
            if (okm[a % 3]) m[a % 3][a] = p;
            for (int k = 0; k < 2; k++)
                if (okm[phys_disk(a, k, 3)]) m[phys_disk(a, k, 3)][a] = d[k*12 +: 12];
        end
    endtask

    task automatic do_inj(input int a, input int s, input logic [11:0] d);
        logic hit;
        hit = (s < 2) && (a < 4) && okm[phys_disk(a, s, 3)];
        inj_valid = 1'b1; inj_addr = 8'(a); inj_slot = 2'(s); inj_data = d;
        tick();
        inj_valid = 1'b0;
        check("inj_wr_done", {63'd0, wr_done}, {63'd0, hit});
        if (hit) m[phys_disk(a, s, 3)][a] = d;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wipe_done) wd_cnt++;
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check("rd_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rd_addr", {56'd0, rd_addr}, {56'd0, mon_e.addr});
                    check("rd_data", {40'd0, rd_data}, {40'd0, mon_e.data});
                    check("rd_parity", {52'd0, rd_parity}, {52'd0, mon_e.par});
                    check("rd_err", {63'd0, rd_err}, {63'd0, mon_e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bc;
        logic [47:0] bw;
        logic [47:0] bexp;
        logic [11:0] bp;

        reset = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0; cmd_parity = 0;
        inj_valid = 0; inj_addr = 0; inj_slot = 0; inj_data = 0;
        fail_valid = 0; fail_disk = 0;
        b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = 0; b_cmd_data = 0; b_cmd_parity = 0;
        b_inj_valid = 0; b_inj_addr = 0; b_inj_slot = 0; b_inj_data = 0;
        b_fail_valid = 0; b_fail_disk = 0;
        model_reset();
        repeat (2) tick();
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_inj_ready", {63'd0, inj_ready}, 64'd1);
        check("rst_disk_ok", {61'd0, disk_ok}, 64'd7);
        check("rst_pulses", {61'd0, rd_valid, wr_done, wipe_done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rd_fields", {28'd0, rd_data, rd_parity}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Wide instance: round trip at addr 7 (parity disk 2), then fail disk 3 to expose slot 2's home.
        bw = {12'h444, 12'h333, 12'h222, 12'h111};
        bp = 12'h5A5;
        b_cmd_valid = 1; b_cmd_write = 1; b_cmd_addr = 8'd7; b_cmd_data = bw; b_cmd_parity = bp;
        tick();
        b_cmd_valid = 0;
        check("w_wr_done", {63'd0, b_wr_done}, 64'd1);
        b_cmd_valid = 1; b_cmd_write = 0;
        tick();
        b_cmd_valid = 0;
        check("w_rd_valid", {63'd0, b_rd_valid}, 64'd1);
        check("w_rd_data", {16'd0, b_rd_data}, {16'd0, bw});
        check("w_rd_parity", {52'd0, b_rd_parity}, {52'd0, bp});
        b_fail_valid = 1; b_fail_disk = 3'd3;
        tick();
        b_fail_valid = 0;
        bc = 0;
        while (b_busy === 1'b1 && bc < 40) begin bc++; tick(); end
        check("w_busy_cycles", 64'(bc), 64'd8);
        check("w_disk_ok", {59'd0, b_disk_ok}, 64'h17);
        bexp = '0;
        for (int k = 0; k < 4; k++)
            if (phys_disk(7, k, 5) != 3) bexp[k*12 +: 12] = bw[k*12 +: 12];
        b_cmd_valid = 1; b_cmd_write = 0;
        tick();
        b_cmd_valid = 0;
        check("w_rd_after_fail", {16'd0, b_rd_data}, {16'd0, bexp});
        check("w_par_after_fail", {52'd0, b_rd_parity}, {52'd0, bp});

        // Basic write then immediate read of the same address.
        do_write(1, {12'h3C3, 12'h0A5}, 12'h666);
        do_read(1);
        tick();
        check("rd_idle_zero", {39'd0, rd_valid, rd_data}, 64'd0);

        do_write(2, {12'h222, 12'h111}, 12'h333);
        do_inj(2, 1, 12'hFFF);
        do_read(2);
        do_inj(2, 2, 12'h123);
        do_inj(6, 0, 12'h456);
        do_read(2);

        do_read(5);
        do_write(5, {12'hBAD, 12'hBAD}, 12'hBAD);
        for (int a = 0; a < 4; a++) do_read(a);

        for (int a = 0; a < 4; a++)
            do_write(a, {12'($urandom), 12'($urandom)}, 12'($urandom));

        // Simultaneous read, injection and fail: served in that order on consecutive edges.
        push_read(3);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'd3;
        inj_valid = 1; inj_addr = 8'd3; inj_slot = 2'd0; inj_data = 12'hABC;
        fail_valid = 1; fail_disk = 2'd0;
        #1;
        check("arb_inj_ready_low", {63'd0, inj_ready}, 64'd0);
        tick();
        cmd_valid = 0;
        #1;
        check("arb_inj_ready_high", {63'd0, inj_ready}, 64'd1);
        check("arb_no_wipe_yet", {63'd0, busy}, 64'd0);
        tick();
        inj_valid = 0;
        check("arb_inj_done", {63'd0, wr_done}, 64'd1);
        m[phys_disk(3, 0, 3)][3] = 12'hABC;
        check("arb_fail_wait", {63'd0, busy}, 64'd0);
        tick();
        fail_valid = 0;
        check("fail_busy", {63'd0, busy}, 64'd1);
        check("fail_disk_ok", {61'd0, disk_ok}, 64'd6);
        okm[0] = 1'b0;
        for (int w = 0; w < 4; w++) m[0][w] = '0;
        wd_exp++;

        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'd0;
        bc = 0;
        while (busy === 1'b1 && bc < 20) begin
            check("wipe_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            bc++;
            tick();
        end
        check("busy_cycles", 64'(bc), 64'd4);
        check("wipe_done_pulse", {63'd0, wipe_done}, 64'd1);
        check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        push_read(0);
        tick();
        cmd_valid = 0;
        check("wipe_done_once", {63'd0, wipe_done}, 64'd0);

        for (int a = 0; a < 4; a++) do_read(a);
        do_write(2, {12'h777, 12'h888}, 12'h999);
        do_read(2);
        do_write(0, {12'h135, 12'h246}, 12'h357);
        do_read(0);

        // Rejected fails: already-failed disk and out-of-range index.
        fail_valid = 1; fail_disk = 2'd0;
        tick();
        fail_valid = 0;
        check("ign_fail_busy", {63'd0, busy}, 64'd0);
        check("ign_fail_done", {63'd0, wipe_done}, 64'd1);
        wd_exp++;
        tick();
        fail_valid = 1; fail_disk = 2'd3;
        tick();
        fail_valid = 0;
        check("oor_fail_busy", {63'd0, busy}, 64'd0);
        check("oor_fail_done", {63'd0, wipe_done}, 64'd1);
        check("oor_disk_ok", {61'd0, disk_ok}, 64'd6);
        wd_exp++;
        tick();

        // Reset in the middle of a wipe of disk 1.
        fail_valid = 1; fail_disk = 2'd1;
        tick();
        fail_valid = 0;
        check("mid_busy", {63'd0, busy}, 64'd1);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_disk_ok", {61'd0, disk_ok}, 64'd7);
        check("mid_rst_pulses", {61'd0, rd_valid, wr_done, wipe_done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
        do_read(1);
        do_read(3);
        repeat (3) tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        check("wipe_done_count", 64'(wd_cnt), 64'(wd_exp));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
